// File: rtl/sst_reg_sequencer.sv
// rtl/sst_reg_sequencer.sv - save-state sequencer walking the mapper sst register space
//
// Purpose: on start_save, reads the header register (map index) and then data
// registers 0..REG_CNT-2 over the sst bus and streams them out. On start_load,
// checks the header byte against the mapper's map index and then writes each
// host byte back into a register. Each write is held across two M2 falling
// edges so that at least one full M2 edge clocks it into the mapper.
//
// Ports:
//   clk, rst_n                 system clock, async active-low reset
//   i_start_save, i_start_load 1-cycle operation requests (save wins if both)
//   i_abort                    synchronous cancel of any running operation
//   i_m2_fall                  1-cycle pulse per CPU M2 falling edge (clk domain)
//   o_sst_act                  save-state bus active
//   o_sst_addr, o_sst_dato     register address / write data
//   o_sst_we_reg               register write strobe
//   i_sst_di                   register read data from the mapper
//   o_out_valid/o_out_data/i_out_ready   save byte stream
//   i_in_valid/i_in_data/o_in_ready      load byte stream
//   o_busy, o_done, o_err      status: running, completion pulse, sticky header mismatch
module sst_reg_sequencer #(
   parameter int REG_CNT = 128,
   parameter int RD_WAIT = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       i_start_save,
   input  logic       i_start_load,
   input  logic       i_abort,
   input  logic       i_m2_fall,
   output logic       o_sst_act,
   output logic [7:0] o_sst_addr,
   output logic [7:0] o_sst_dato,
   output logic       o_sst_we_reg,
   input  logic [7:0] i_sst_di,
   output logic       o_out_valid,
   output logic [7:0] o_out_data,
   input  logic       i_out_ready,
   input  logic       i_in_valid,
   input  logic [7:0] i_in_data,
   output logic       o_in_ready,
   output logic       o_busy,
   output logic       o_done,
   output logic       o_err
);

   localparam logic [7:0] HDR_ADDR = 8'(REG_CNT - 1);
   localparam logic [7:0] LAST_IDX = 8'(REG_CNT - 2);
   localparam logic [7:0] RD_LAST  = 8'(RD_WAIT);
   localparam logic [7:0] HDR_LAST = 8'(RD_WAIT - 1);

   typedef enum logic [2:0] {
      ST_IDLE, ST_S_RD, ST_S_OUT, ST_L_HDR, ST_L_IN, ST_L_WR, ST_FIN
   } state_t;

   state_t     r_state;
   logic [7:0] r_idx;
   logic [7:0] r_wait;
   logic       r_m2_seen;
   logic       r_sst_act;
   logic [7:0] r_sst_addr;
   logic [7:0] r_sst_dato;
   logic       r_sst_we_reg;
   logic       r_out_valid;
   logic [7:0] r_out_data;
   logic       r_in_ready;
   logic       r_busy;
   logic       r_done;
   logic       r_err;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= ST_IDLE;
         r_idx        <= 8'h00;
         r_wait       <= 8'h00;
         r_m2_seen    <= 1'b0;
         r_sst_act    <= 1'b0;
         r_sst_addr   <= 8'h00;
         r_sst_dato   <= 8'h00;
         r_sst_we_reg <= 1'b0;
         r_out_valid  <= 1'b0;
         r_out_data   <= 8'h00;
         r_in_ready   <= 1'b0;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
         r_err        <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (i_abort && (r_state != ST_IDLE)) begin
            // An in-flight write is dropped before its second M2 edge, so the
            // mapper never commits it.
            r_state      <= ST_IDLE;
            r_sst_act    <= 1'b0;
            r_sst_we_reg <= 1'b0;
            r_out_valid  <= 1'b0;
            r_in_ready   <= 1'b0;
            r_busy       <= 1'b0;
         end else begin
            case (r_state)
               ST_IDLE: begin
                  if (i_start_save || i_start_load) begin
                     r_state    <= i_start_save ? ST_S_RD : ST_L_HDR;
                     r_sst_addr <= HDR_ADDR;
                     r_wait     <= 8'h00;
                     r_sst_act  <= 1'b1;
                     r_busy     <= 1'b1;
                     r_err      <= 1'b0;
                  end
               end
               ST_S_RD: begin
                  // Address has been stable RD_WAIT cycles once r_wait hits RD_LAST.
                  if (r_wait == RD_LAST) begin
                     r_out_data  <= i_sst_di;
                     r_out_valid <= 1'b1;
                     r_state     <= ST_S_OUT;
                  end else begin
                     r_wait <= r_wait + 8'h01;
                  end
               end
               ST_S_OUT: begin
                  if (i_out_ready) begin
                     r_out_valid <= 1'b0;
                     r_wait      <= 8'h00;
                     if (r_sst_addr == HDR_ADDR) begin
                        r_idx      <= 8'h00;
                        r_sst_addr <= 8'h00;
                        r_state    <= ST_S_RD;
                     end else if (r_idx < LAST_IDX) begin
                        r_idx      <= r_idx + 8'h01;
                        r_sst_addr <= r_idx + 8'h01;
                        r_state    <= ST_S_RD;
                     end else begin
                        r_done  <= 1'b1;
                        r_state <= ST_FIN;
                     end
                  end
               end
               ST_L_HDR: begin
                  // in_ready rises only after the header address has settled,
                  // so i_sst_di is valid whenever the header byte is accepted.
                  if (!r_in_ready) begin
                     if (r_wait == HDR_LAST) begin
                        r_in_ready <= 1'b1;
                     end else begin
                        r_wait <= r_wait + 8'h01;
                     end
                  end else if (i_in_valid) begin
                     if (i_in_data == i_sst_di) begin
                        r_idx   <= 8'h00;
                        r_state <= ST_L_IN;
                     end else begin
                        r_err      <= 1'b1;
                        r_sst_act  <= 1'b0;
                        r_busy     <= 1'b0;
                        r_in_ready <= 1'b0;
                        r_state    <= ST_IDLE;
                     end
                  end
               end
               ST_L_IN: begin
                  if (i_in_valid) begin
                     r_sst_dato   <= i_in_data;
                     r_sst_addr   <= r_idx;
                     r_sst_we_reg <= 1'b1;
                     r_in_ready   <= 1'b0;
                     r_m2_seen    <= 1'b0;
                     r_state      <= ST_L_WR;
                  end
               end
               ST_L_WR: begin
                  // The first M2 fall may belong to an M2 cycle that started
                  // before the strobe rose; only the second one is complete.
                  if (i_m2_fall) begin
                     if (!r_m2_seen) begin
                        r_m2_seen <= 1'b1;
                     end else begin
                        r_sst_we_reg <= 1'b0;
                        if (r_idx == LAST_IDX) begin
                           r_done  <= 1'b1;
                           r_state <= ST_FIN;
                        end else begin
                           r_idx      <= r_idx + 8'h01;
                           r_in_ready <= 1'b1;
                           r_state    <= ST_L_IN;
                        end
                     end
                  end
               end
               ST_FIN: begin
                  r_sst_act <= 1'b0;
                  r_busy    <= 1'b0;
                  r_state   <= ST_IDLE;
               end
               default: begin
                  r_state <= ST_IDLE;
               end
            endcase
         end
      end
   end

   assign o_sst_act    = r_sst_act;
   assign o_sst_addr   = r_sst_addr;
   assign o_sst_dato   = r_sst_dato;
   assign o_sst_we_reg = r_sst_we_reg;
   assign o_out_valid  = r_out_valid;
   assign o_out_data   = r_out_data;
   assign o_in_ready   = r_in_ready;
   assign o_busy       = r_busy;
   assign o_done       = r_done;
   assign o_err        = r_err;

endmodule

// File: tb/tb_sst_reg_sequencer.sv
// tb/tb_sst_reg_sequencer.sv - directed self-checking bench for sst_reg_sequencer
module tb_sst_reg_sequencer;

   localparam int REG_CNT = 4;
   localparam int RD_WAIT = 2;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       i_start_save = 1'b0;
   logic       i_start_load = 1'b0;
   logic       i_abort = 1'b0;
   logic       i_m2_fall;
   logic       o_sst_act;
   logic [7:0] o_sst_addr;
   logic [7:0] o_sst_dato;
   logic       o_sst_we_reg;
   logic [7:0] i_sst_di;
   logic       o_out_valid;
   logic [7:0] o_out_data;
   logic       i_out_ready = 1'b0;
   logic       i_in_valid = 1'b0;
   logic [7:0] i_in_data = 8'h00;
   logic       o_in_ready;
   logic       o_busy;
   logic       o_done;
   logic       o_err;

   int n_cmp = 0;
   int n_bad = 0;

   sst_reg_sequencer #(.REG_CNT(REG_CNT), .RD_WAIT(RD_WAIT)) dut (
      .clk(clk), .rst_n(rst_n),
      .i_start_save(i_start_save), .i_start_load(i_start_load),
      .i_abort(i_abort), .i_m2_fall(i_m2_fall),
      .o_sst_act(o_sst_act), .o_sst_addr(o_sst_addr), .o_sst_dato(o_sst_dato),
      .o_sst_we_reg(o_sst_we_reg), .i_sst_di(i_sst_di),
      .o_out_valid(o_out_valid), .o_out_data(o_out_data), .i_out_ready(i_out_ready),
      .i_in_valid(i_in_valid), .i_in_data(i_in_data), .o_in_ready(o_in_ready),
      .o_busy(o_busy), .o_done(o_done), .o_err(o_err)
   );

   always #5 clk = ~clk;

   // Mapper model: header register holds map_idx, data registers are regs[].
   logic [7:0]      map_idx = 8'h59;
   logic [2:0][7:0] regs = '0;
   always_comb begin
      i_sst_di = 8'h00;
      if (o_sst_addr == 8'(REG_CNT - 1)) i_sst_di = map_idx;
      else if (o_sst_addr < 8'(REG_CNT - 1)) i_sst_di = regs[o_sst_addr[1:0]];
   end

   // M2 falling-edge pulse every 6 clocks.
   int m2_ph = 0;
   initial begin
      i_m2_fall = 1'b0;
      forever begin
         @(posedge clk); #1;
         m2_ph = (m2_ph == 5) ? 0 : m2_ph + 1;
         i_m2_fall = (m2_ph == 0);
      end
   end

   // Write-window monitor: records address, data and M2 pulses seen per we_reg window.
   logic       we_prev = 1'b0;
   logic [7:0] cur_a = 8'h00;
   logic [7:0] cur_d = 8'h00;
   int         cur_m2 = 0;
   int         win_cnt = 0;
   int         stab_bad = 0;
   logic [7:0] wa [64];
   logic [7:0] wd [64];
   int         wm [64];
   always @(negedge clk) begin
      if (o_sst_we_reg) begin
         if (!we_prev) begin
            cur_a = o_sst_addr;
            cur_d = o_sst_dato;
            cur_m2 = 0;
         end else if (o_sst_addr !== cur_a || o_sst_dato !== cur_d) begin
            stab_bad++;
         end
         if (i_m2_fall) cur_m2++;
      end else if (we_prev) begin
         wa[win_cnt[5:0]] = cur_a;
         wd[win_cnt[5:0]] = cur_d;
         wm[win_cnt[5:0]] = cur_m2;
         win_cnt++;
      end
      we_prev = o_sst_we_reg;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic run_save(input logic both, input logic mid_load, input int stall_byte,
                           input int stall_n, output logic [3:0][7:0] got, output int nb,
                           output int nd, output int cyc, output int unstable, output int rdy_seen);
      int stall_left;
      logic [7:0] held;
      logic first;
      got = '0; nb = 0; nd = 0; cyc = 0; unstable = 0; rdy_seen = 0;
      stall_left = stall_n; held = 8'h00; first = 1'b1;
      i_start_save = 1'b1;
      i_start_load = both;
      @(posedge clk); #1;
      i_start_save = 1'b0;
      i_start_load = 1'b0;
      while (cyc < 300) begin
         i_start_load = mid_load && (cyc == 5);
         if (o_out_valid && nb == stall_byte && stall_left > 0) begin
            i_out_ready = 1'b0;
            if (first) begin
               held = o_out_data;
               first = 1'b0;
            end else if (o_out_data !== held) begin
               unstable++;
            end
            stall_left--;
         end else begin
            i_out_ready = 1'b1;
         end
         if (o_out_valid && i_out_ready) begin
            if (nb < 4) got[nb[1:0]] = o_out_data;
            nb++;
         end
         if (o_done) nd++;
         if (o_in_ready) rdy_seen++;
         @(posedge clk); #1;
         cyc++;
         if (!o_busy) break;
      end
      i_start_load = 1'b0;
      i_out_ready = 1'b0;
   endtask

   task automatic run_load(input logic [3:0][7:0] b, output int nd, output int hs);
      int k;
      int cyc;
      logic h;
      nd = 0; hs = 0; k = 0; cyc = 0;
      i_start_load = 1'b1;
      @(posedge clk); #1;
      i_start_load = 1'b0;
      i_in_valid = 1'b1;
      i_in_data = b[0];
      while (cyc < 600) begin
         h = o_in_ready && i_in_valid;
         if (o_done) nd++;
         @(posedge clk); #1;
         cyc++;
         if (h) begin
            hs++;
            k++;
            if (k < 4) i_in_data = b[k[1:0]];
            else i_in_valid = 1'b0;
         end
         if (!o_busy) break;
      end
      i_in_valid = 1'b0;
   endtask

   typedef struct {
      logic            is_load;
      logic [7:0]      mi;
      logic [2:0][7:0] r;
      logic [3:0][7:0] bytes;   // save: expected stream; load: host stream
      int              stall_byte;
      int              stall_n;
      int              exp_cyc;
      int              exp_hs;
      int              exp_win;
      int              exp_done;
      logic            exp_err;
   } vec_t;

   vec_t vecs [5];

   initial begin
      logic [3:0][7:0] got;
      int nb, nd, cyc, unst, rdy, hs, base, wi, k;
      logic h, hit;

      vecs[0] = '{is_load:1'b0, mi:8'h59, r:{8'h01, 8'h0A, 8'h13}, bytes:{8'h01, 8'h0A, 8'h13, 8'h59},
                  stall_byte:-1, stall_n:0, exp_cyc:17, exp_hs:0, exp_win:0, exp_done:1, exp_err:1'b0};
      vecs[1] = '{is_load:1'b0, mi:8'hA5, r:{8'h7E, 8'h00, 8'hFF}, bytes:{8'h7E, 8'h00, 8'hFF, 8'hA5},
                  stall_byte:-1, stall_n:0, exp_cyc:17, exp_hs:0, exp_win:0, exp_done:1, exp_err:1'b0};
      vecs[2] = '{is_load:1'b1, mi:8'h59, r:{8'h01, 8'h0A, 8'h13}, bytes:{8'h01, 8'h07, 8'h22, 8'h59},
                  stall_byte:-1, stall_n:0, exp_cyc:0, exp_hs:4, exp_win:3, exp_done:1, exp_err:1'b0};
      vecs[3] = '{is_load:1'b1, mi:8'h59, r:{8'h01, 8'h0A, 8'h13}, bytes:{8'h01, 8'h07, 8'h22, 8'h42},
                  stall_byte:-1, stall_n:0, exp_cyc:0, exp_hs:1, exp_win:0, exp_done:0, exp_err:1'b1};
      vecs[4] = '{is_load:1'b0, mi:8'h59, r:{8'h01, 8'h0A, 8'h13}, bytes:{8'h01, 8'h0A, 8'h13, 8'h59},
                  stall_byte:2, stall_n:5, exp_cyc:22, exp_hs:0, exp_win:0, exp_done:1, exp_err:1'b0};

      repeat (3) @(posedge clk);
      #1;
      chk("reset_data", 32'({o_sst_addr, o_sst_dato, o_out_data}), 32'h0);
      chk("reset_flags", 32'({o_sst_act, o_sst_we_reg, o_out_valid, o_in_ready, o_busy, o_done, o_err}), 32'h0);
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;

      for (int v = 0; v < 5; v++) begin
         map_idx = vecs[v].mi;
         regs = vecs[v].r;
         base = win_cnt;
         if (!vecs[v].is_load) begin
            run_save(1'b0, 1'b0, vecs[v].stall_byte, vecs[v].stall_n, got, nb, nd, cyc, unst, rdy);
            chk($sformatf("v%0d_nbytes", v), nb, 4);
            for (int b = 0; b < 4; b++)
               chk($sformatf("v%0d_byte%0d", v, b), 32'(got[b[1:0]]), 32'(vecs[v].bytes[b[1:0]]));
            chk($sformatf("v%0d_cycles", v), cyc, vecs[v].exp_cyc);
            chk($sformatf("v%0d_out_data_stable", v), unst, 0);
            chk($sformatf("v%0d_in_ready_seen", v), rdy, 0);
         end else begin
            run_load(vecs[v].bytes, nd, hs);
            chk($sformatf("v%0d_handshakes", v), hs, vecs[v].exp_hs);
         end
         @(negedge clk); #1;
         chk($sformatf("v%0d_done_pulses", v), nd, vecs[v].exp_done);
         chk($sformatf("v%0d_err", v), 32'(o_err), 32'(vecs[v].exp_err));
         chk($sformatf("v%0d_busy_after", v), 32'(o_busy), 32'h0);
         chk($sformatf("v%0d_act_after", v), 32'(o_sst_act), 32'h0);
         chk($sformatf("v%0d_windows", v), win_cnt - base, vecs[v].exp_win);
         for (int w = 0; w < vecs[v].exp_win; w++) begin
            k = base + w;
            wi = w + 1;
            chk($sformatf("v%0d_win%0d_addr", v, w), 32'(wa[k[5:0]]), w);
            chk($sformatf("v%0d_win%0d_dato", v, w), 32'(wd[k[5:0]]), 32'(vecs[v].bytes[wi[1:0]]));
            chk($sformatf("v%0d_win%0d_m2", v, w), wm[k[5:0]], 2);
         end
         chk($sformatf("v%0d_we_stable", v), stab_bad, 0);
         repeat (3) @(posedge clk);
         #1;
      end

      // Simultaneous starts: save wins; a start_load mid-save is ignored.
      map_idx = 8'h59;
      regs = {8'h01, 8'h0A, 8'h13};
      base = win_cnt;
      run_save(1'b1, 1'b1, -1, 0, got, nb, nd, cyc, unst, rdy);
      chk("both_nbytes", nb, 4);
      chk("both_byte0", 32'(got[0]), 32'h59);
      chk("both_byte3", 32'(got[3]), 32'h01);
      chk("both_in_ready_seen", rdy, 0);
      chk("both_done", nd, 1);
      chk("both_cycles", cyc, 17);
      @(negedge clk); #1;
      chk("both_windows", win_cnt - base, 0);
      repeat (3) @(posedge clk);
      #1;

      // Abort in L_WR after the first m2_fall of the window.
      base = win_cnt;
      i_start_load = 1'b1;
      @(posedge clk); #1;
      i_start_load = 1'b0;
      i_in_valid = 1'b1;
      i_in_data = 8'h59;
      k = 0;
      hit = 1'b0;
      nd = 0;
      for (int c = 0; c < 200; c++) begin
         h = o_in_ready && i_in_valid;
         @(posedge clk); #2;
         if (o_done) nd++;
         if (h) begin
            k++;
            if (k == 1) i_in_data = 8'h22;
            else i_in_valid = 1'b0;
         end
         if (o_sst_we_reg && i_m2_fall) begin
            hit = 1'b1;
            break;
         end
      end
      chk("abort_first_m2_reached", 32'(hit), 32'h1);
      @(posedge clk); #1;
      i_abort = 1'b1;
      chk("abort_we_before", 32'(o_sst_we_reg), 32'h1);
      @(posedge clk); #1;
      i_abort = 1'b0;
      if (o_done) nd++;
      chk("abort_flags", 32'({o_sst_we_reg, o_busy, o_sst_act, o_in_ready, o_out_valid}), 32'h0);
      @(posedge clk); #1;
      if (o_done) nd++;
      chk("abort_no_done", nd, 0);
      chk("abort_err_unchanged", 32'(o_err), 32'h0);
      @(negedge clk); #1;
      chk("abort_windows", win_cnt - base, 1);
      chk("abort_win_addr", 32'(wa[base[5:0]]), 32'h0);
      chk("abort_win_dato", 32'(wd[base[5:0]]), 32'h22);
      chk("abort_win_m2", wm[base[5:0]], 1);
      repeat (3) @(posedge clk);
      #1;

      // Asynchronous reset mid-save.
      i_out_ready = 1'b1;
      i_start_save = 1'b1;
      @(posedge clk); #1;
      i_start_save = 1'b0;
      repeat (6) @(posedge clk);
      #3;
      chk("midrst_busy_before", 32'({o_busy, o_sst_act}), 32'h3);
      rst_n = 1'b0;
      #1;
      chk("midrst_data", 32'({o_sst_addr, o_sst_dato, o_out_data}), 32'h0);
      chk("midrst_flags", 32'({o_sst_act, o_sst_we_reg, o_out_valid, o_in_ready, o_busy, o_done, o_err}), 32'h0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      i_out_ready = 1'b0;
      repeat (2) @(posedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: got timeout, expected finish");
      $fatal(1);
   end

endmodule
